// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcodes, datapath widths
// and the record of instruction fields captured from decode.
package mips_pkg;

    localparam int CPU_DATA_W  = 32;
    localparam int CPU_REG_AW  = 5;
    localparam int CPU_SEL_W   = 3;
    localparam int CPU_IMM_W   = 16;
    localparam int CPU_SHAMT_W = 5;

    typedef enum logic [CPU_SEL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic                   valid;
        logic [CPU_REG_AW-1:0]  rs;
        logic [CPU_REG_AW-1:0]  rt;
        logic [CPU_DATA_W-1:0]  rs_data;
        logic [CPU_DATA_W-1:0]  rt_data;
        logic [CPU_IMM_W-1:0]   imm;
        logic                   imm_sext;
        logic                   src_imm;
        logic [CPU_SHAMT_W-1:0] shamt;
        logic                   use_shamt;
        logic [CPU_SEL_W-1:0]   alu_sel;
        logic                   sign1;
        logic                   sign2;
        logic [CPU_REG_AW-1:0]  rd;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
    } stage_t;

    function automatic logic [CPU_DATA_W-1:0] ext_imm(input logic [CPU_IMM_W-1:0] imm,
                                                      input logic                 sext);
        return sext ? {{(CPU_DATA_W-CPU_IMM_W){imm[CPU_IMM_W-1]}}, imm}
                    : {{(CPU_DATA_W-CPU_IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/forward_mux.sv
// Single-source operand forwarding: EX/MEM beats MEM/WB beats the value read
// from the register file; register 0 is never forwarded.
module forward_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_exm_we,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [DATA_W-1:0] i_exm_data,
    input  logic              i_mwb_we,
    input  logic [REG_AW-1:0] i_mwb_rd,
    input  logic [DATA_W-1:0] i_mwb_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_src_nz;
    logic w_exm_hit;
    logic w_mwb_hit;

    always_comb begin
        w_src_nz  = (i_src != '0);
        w_exm_hit = i_exm_we && (i_exm_rd == i_src) && w_src_nz;
        w_mwb_hit = i_mwb_we && (i_mwb_rd == i_src) && w_src_nz;
        o_data    = i_reg_data;
        if (w_exm_hit) begin
            o_data = i_exm_data;
        end else if (w_mwb_hit) begin
            o_data = i_mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, forwards
// from EX/MEM and MEM/WB, selects immediates/shamt, and bubbles on load-use.
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              id_imm_sext,
    input  logic              id_src_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_use_shamt,
    input  logic [SEL_W-1:0]  id_alu_sel,
    input  logic              id_sign1,
    input  logic              id_sign2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_alu_a,
    output logic [DATA_W-1:0] ex_alu_b,
    output logic [SEL_W-1:0]  ex_alu_sel,
    output logic              ex_sign1,
    output logic              ex_sign2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    stage_t            r_stage;
    stage_t            w_id_rec;
    logic              w_stall;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    always_comb begin
        w_id_rec           = '0;
        w_id_rec.valid     = id_valid;
        w_id_rec.rs        = id_rs;
        w_id_rec.rt        = id_rt;
        w_id_rec.rs_data   = id_rs_data;
        w_id_rec.rt_data   = id_rt_data;
        w_id_rec.imm       = id_imm;
        w_id_rec.imm_sext  = id_imm_sext;
        w_id_rec.src_imm   = id_src_imm;
        w_id_rec.shamt     = id_shamt;
        w_id_rec.use_shamt = id_use_shamt;
        w_id_rec.alu_sel   = id_alu_sel;
        w_id_rec.sign1     = id_sign1;
        w_id_rec.sign2     = id_sign2;
        w_id_rec.rd        = id_rd;
        w_id_rec.reg_write = id_reg_write;
        w_id_rec.mem_read  = id_mem_read;
        w_id_rec.mem_write = id_mem_write;
    end

    // A load in EX cannot feed a consumer in ID this cycle; a flush kills the
    // consumer anyway, so it suppresses the stall.
    always_comb begin
        w_stall = r_stage.valid && r_stage.mem_read && (r_stage.rd != '0) && id_valid &&
                  ((id_rs_used && (id_rs == r_stage.rd)) ||
                   (id_rt_used && (id_rt == r_stage.rd))) && !flush;
    end

    // ID -> EX boundary; bubbles are fully zeroed so operands never go X.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '0;
        end else if (flush || w_stall) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_id_rec;
        end
    end

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_src      (r_stage.rs),
        .i_reg_data (r_stage.rs_data),
        .i_exm_we   (exm_reg_write),
        .i_exm_rd   (exm_rd),
        .i_exm_data (exm_result),
        .i_mwb_we   (mwb_reg_write),
        .i_mwb_rd   (mwb_rd),
        .i_mwb_data (mwb_result),
        .o_data     (w_fwd_rs)
    );

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_src      (r_stage.rt),
        .i_reg_data (r_stage.rt_data),
        .i_exm_we   (exm_reg_write),
        .i_exm_rd   (exm_rd),
        .i_exm_data (exm_result),
        .i_mwb_we   (mwb_reg_write),
        .i_mwb_rd   (mwb_rd),
        .i_mwb_data (mwb_result),
        .o_data     (w_fwd_rt)
    );

    // Shift instructions shift the rt value by shamt, overriding any immediate.
    always_comb begin
        if (r_stage.use_shamt) begin
            ex_alu_a = w_fwd_rt;
            ex_alu_b = {{(DATA_W-5){1'b0}}, r_stage.shamt};
        end else begin
            ex_alu_a = w_fwd_rs;
            ex_alu_b = r_stage.src_imm ? ext_imm(r_stage.imm, r_stage.imm_sext) : w_fwd_rt;
        end
        stall_id      = w_stall;
        ex_valid      = r_stage.valid;
        ex_store_data = w_fwd_rt;
        ex_alu_sel    = r_stage.alu_sel;
        ex_sign1      = r_stage.sign1;
        ex_sign2      = r_stage.sign2;
        ex_rd         = r_stage.rd;
        ex_reg_write  = r_stage.valid && r_stage.reg_write;
        ex_mem_read   = r_stage.valid && r_stage.mem_read;
        ex_mem_write  = r_stage.valid && r_stage.mem_write;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed pipeline scenarios then
// randomized traffic against an instruction-level reference model.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_valid, id_rs_used, id_rt_used, id_imm_sext, id_src_imm, id_use_shamt;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [2:0]  id_alu_sel;
    logic        id_sign1, id_sign2, id_reg_write, id_mem_read, id_mem_write, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        stall_id, ex_valid, ex_sign1, ex_sign2;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [2:0]  ex_alu_sel;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_imm_sext(id_imm_sext), .id_src_imm(id_src_imm),
        .id_shamt(id_shamt), .id_use_shamt(id_use_shamt), .id_alu_sel(id_alu_sel),
        .id_sign1(id_sign1), .id_sign2(id_sign2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_sel(ex_alu_sel),
        .ex_sign1(ex_sign1), .ex_sign2(ex_sign2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    // One instruction as the model sees it; chk marks whether its data is defined.
    typedef struct {
        bit          chk;
        logic        valid;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] rs_data, rt_data;
        logic [15:0] imm;
        logic        sext, src_imm, use_shamt, s1, s2, rw, mr, mw;
        logic [2:0]  sel;
    } ins_t;

    typedef struct {
        bit          chk;
        logic        stall, valid, rw, mr, mw, s1, s2;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] a, b, st;
    } exp_t;

    exp_t q[$];
    ins_t ex_m;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t zero_ins(input bit c);
        ins_t z;
        z = '{chk: c, valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, shamt: 5'd0,
              rs_data: 32'd0, rt_data: 32'd0, imm: 16'd0, sext: 1'b0, src_imm: 1'b0,
              use_shamt: 1'b0, s1: 1'b0, s2: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, sel: 3'd0};
        return z;
    endfunction

    function automatic ins_t id_ins();
        ins_t n;
        n = '{chk: 1'b1, valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, shamt: id_shamt,
              rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm, sext: id_imm_sext,
              src_imm: id_src_imm, use_shamt: id_use_shamt, s1: id_sign1, s2: id_sign2,
              rw: id_reg_write, mr: id_mem_read, mw: id_mem_write, sel: id_alu_sel};
        return n;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0)                         return d;
        if (exm_reg_write && exm_rd == r)      return exm_result;
        if (mwb_reg_write && mwb_rd == r)      return mwb_result;
        return d;
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model one clock.
    task automatic advance();
        exp_t        e;
        ins_t        nxt;
        logic        st;
        logic [31:0] fa, ft;
        int          immv;
        st = ex_m.valid && ex_m.mr && (ex_m.rd != 5'd0) && id_valid &&
             ((id_rs_used && id_rs == ex_m.rd) || (id_rt_used && id_rt == ex_m.rd)) && !flush;
        fa = fwd(ex_m.rs, ex_m.rs_data);
        ft = fwd(ex_m.rt, ex_m.rt_data);
        immv = ex_m.sext ? int'($signed(ex_m.imm)) : int'(ex_m.imm);
        e.chk = ex_m.chk; e.stall = st; e.valid = ex_m.valid;
        e.rw = ex_m.valid & ex_m.rw; e.mr = ex_m.valid & ex_m.mr; e.mw = ex_m.valid & ex_m.mw;
        e.rd = ex_m.rd; e.sel = ex_m.sel; e.s1 = ex_m.s1; e.s2 = ex_m.s2; e.st = ft;
        if (ex_m.use_shamt) begin
            e.a = ft; e.b = 32'(ex_m.shamt);
        end else begin
            e.a = fa; e.b = ex_m.src_imm ? 32'(immv) : ft;
        end
        q.push_back(e);
        if (reset)            nxt = zero_ins(1'b1);
        else if (flush || st) nxt = zero_ins(1'b0);
        else                  nxt = id_ins();
        @(posedge clk);
        #1;
        ex_m = nxt;
    endtask

    task automatic clear_id();
        reset = 0; flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_imm_sext = 0; id_src_imm = 0;
        id_shamt = 0; id_use_shamt = 0; id_alu_sel = 0; id_sign1 = 0; id_sign2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    task automatic set_all_ones();
        reset = 1; flush = 1;
        id_valid = 1; id_rs = '1; id_rt = '1; id_rs_used = 1; id_rt_used = 1;
        id_rs_data = '1; id_rt_data = '1; id_imm = '1; id_imm_sext = 1; id_src_imm = 1;
        id_shamt = '1; id_use_shamt = 1; id_alu_sel = '1; id_sign1 = 1; id_sign2 = 1;
        id_rd = '1; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
        exm_reg_write = 1; exm_rd = '1; exm_result = '1;
        mwb_reg_write = 1; mwb_rd = '1; mwb_result = '1;
    endtask

    task automatic rand_inputs();
        reset        = ($urandom_range(0, 40) == 0);
        flush        = ($urandom_range(0, 9) == 0);
        id_valid     = ($urandom_range(0, 7) != 0);
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        id_rd        = 5'($urandom_range(0, 3));
        id_rs_used   = 1'($urandom_range(0, 1));
        id_rt_used   = 1'($urandom_range(0, 1));
        id_rs_data   = $urandom;
        id_rt_data   = $urandom;
        id_imm       = 16'($urandom);
        id_imm_sext  = 1'($urandom_range(0, 1));
        id_src_imm   = 1'($urandom_range(0, 1));
        id_shamt     = 5'($urandom);
        id_use_shamt = ($urandom_range(0, 4) == 0);
        id_alu_sel   = 3'($urandom);
        id_sign1     = 1'($urandom_range(0, 1));
        id_sign2     = 1'($urandom_range(0, 1));
        id_reg_write = 1'($urandom_range(0, 1));
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_mem_write = ($urandom_range(0, 3) == 0);
        exm_reg_write = 1'($urandom_range(0, 1));
        exm_rd        = 5'($urandom_range(0, 3));
        exm_result    = $urandom;
        mwb_reg_write = 1'($urandom_range(0, 1));
        mwb_rd        = 5'($urandom_range(0, 3));
        mwb_result    = $urandom;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall_id",     32'(stall_id),     32'(e.stall));
            chk("ex_valid",     32'(ex_valid),     32'(e.valid));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
            chk("ex_mem_read",  32'(ex_mem_read),  32'(e.mr));
            chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
            chk("operands_known", 32'($isunknown({ex_alu_a, ex_alu_b, ex_store_data})), 32'd0);
            if (e.chk) begin
                chk("ex_rd",         32'(ex_rd),      32'(e.rd));
                chk("ex_alu_sel",    32'(ex_alu_sel), 32'(e.sel));
                chk("ex_sign1",      32'(ex_sign1),   32'(e.s1));
                chk("ex_sign2",      32'(ex_sign2),   32'(e.s2));
                chk("ex_alu_a",      ex_alu_a,        e.a);
                chk("ex_alu_b",      ex_alu_b,        e.b);
                chk("ex_store_data", ex_store_data,   e.st);
            end
        end
    end

    initial begin
        // Reset with every input driven high.
        set_all_ones();
        @(posedge clk);
        #1;
        ex_m = zero_ins(1'b1);
        advance();
        advance();

        // add r3, r1(=5), r2(=7)
        clear_id();
        id_valid = 1; id_rs = 1; id_rt = 2; id_rs_used = 1; id_rt_used = 1;
        id_rs_data = 32'd5; id_rt_data = 32'd7; id_rd = 3; id_reg_write = 1; id_alu_sel = 3'b000;
        advance();
        clear_id();
        advance();

        // Both later stages write r4: EX/MEM wins.
        id_valid = 1; id_rs = 4; id_rs_used = 1; id_rs_data = 32'h99; id_rd = 6; id_reg_write = 1;
        advance();
        clear_id();
        exm_reg_write = 1; exm_rd = 4; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 4; mwb_result = 32'h22;
        advance();

        // r0 is never forwarded.
        clear_id();
        id_valid = 1; id_rs = 0; id_rs_used = 1; id_rs_data = 32'h55;
        advance();
        clear_id();
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'h22;
        advance();

        // MEM/WB-only forward of rt into b and store data.
        clear_id();
        id_valid = 1; id_rt = 7; id_rt_used = 1; id_rt_data = 32'h1; id_mem_write = 1;
        advance();
        clear_id();
        mwb_reg_write = 1; mwb_rd = 7; mwb_result = 32'hCAFE;
        advance();

        // Immediates: sign- then zero-extended 0xFFFF, then shamt beating src_imm.
        clear_id();
        id_valid = 1; id_src_imm = 1; id_imm = 16'hFFFF; id_imm_sext = 1;
        advance();
        clear_id();
        id_valid = 1; id_src_imm = 1; id_imm = 16'hFFFF; id_imm_sext = 0;
        advance();
        clear_id();
        id_valid = 1; id_use_shamt = 1; id_src_imm = 1; id_shamt = 5'd3;
        id_rt = 2; id_rt_data = 32'h8; id_alu_sel = 3'b101;
        advance();
        clear_id();
        advance();

        // Load-use on r5: one stall, bubble, then the consumer with a forwarded operand.
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5;
        advance();
        clear_id();
        id_valid = 1; id_rs = 5; id_rs_used = 1; id_rt = 1; id_rt_used = 1;
        id_rt_data = 32'h3; id_rd = 6; id_reg_write = 1;
        advance();
        advance();
        clear_id();
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'hABCD;
        advance();

        // Flush coinciding with a load-use hazard.
        clear_id();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5;
        advance();
        clear_id();
        id_valid = 1; id_rs = 5; id_rs_used = 1; id_rd = 9; id_reg_write = 1; flush = 1;
        advance();
        clear_id();
        advance();

        // Reset asserted while a stall is pending.
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5;
        advance();
        clear_id();
        id_valid = 1; id_rt = 5; id_rt_used = 1; reset = 1;
        advance();
        reset = 0;
        advance();

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            advance();
        end

        clear_id();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-delivery stage that drives the 32-bit ALU's a, b, sign1, sign2 and S inputs.
- Registers decoded instruction fields from ID.
- Resolves EX/MEM and MEM/WB forwarding at the EX side.
- Substitutes immediate or shift amount for b.
- Detects load-use hazards and inserts bubbles.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.
- SEL_W, 3, ALU opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW each  source indices.
- id_rs_used, id_rt_used  in  1 each  source actually read.
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data.
- id_imm  in  16  raw immediate.
- id_imm_sext  in  1  1 = sign-extend, 0 = zero-extend.
- id_src_imm  in  1  b takes the extended immediate.
- id_shamt  in  5  shift amount.
- id_use_shamt  in  1  a = rt value, b = zero-extended shamt.
- id_alu_sel  in  SEL_W  ALU opcode.
- id_sign1, id_sign2  in  1 each  ALU abs-value controls.
- id_rd  in  REG_AW  destination.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control.
- flush  in  1  branch/jump kill of the ID instruction.
- exm_reg_write  in  1  EX/MEM write enable.
- exm_rd  in  REG_AW  EX/MEM destination.
- exm_result  in  DATA_W  EX/MEM result.
- mwb_reg_write  in  1  MEM/WB write enable.
- mwb_rd  in  REG_AW  MEM/WB destination.
- mwb_result  in  DATA_W  MEM/WB result.
- stall_id  out  1  hold PC and IF/ID.
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_a, ex_alu_b  out  DATA_W each  ALU operands.
- ex_alu_sel  out  SEL_W  ALU opcode.
- ex_sign1, ex_sign2  out  1 each  ALU sign controls.
- ex_store_data  out  DATA_W  forwarded rt value for stores.
- ex_rd  out  REG_AW  destination.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control, gated by ex_valid.

Behaviour:
- Stage register, loaded every rising clk edge. Exactly one of the following applies, in priority order:
  - reset: all fields 0, ex_valid = 0.
  - flush or stall_id: load a bubble (ex_valid = 0, all control 0; data fields don't-care).
  - otherwise: capture all id_* fields; ex_valid = id_valid.
- Latency: one cycle from ID capture to valid EX operands.
- Forwarded values are combinational from the stage register and the exm_*/mwb_* inputs; no added cycle.
- Forwarding, per source s in {rs, rt}:
  - fwd_s = exm_result if exm_reg_write and exm_rd == s and s != 0;
  - else mwb_result if mwb_reg_write and mwb_rd == s and s != 0;
  - else the registered data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand select:
  - id_use_shamt captured: ex_alu_a = fwd_rt, ex_alu_b = {27'b0, shamt}.
  - else ex_alu_a = fwd_rs, and ex_alu_b = extended immediate if src_imm, otherwise fwd_rt.
  - Extension follows imm_sext. Shamt takes priority over src_imm.
  - ex_store_data = fwd_rt always.
- The ALU's is0 compares its raw a and b, so ex_alu_a/b must always be the forwarded values.
- Load-use hazard, combinational:
  - stall_id = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_rs_used & id_rs == ex_rd) | (id_rt_used & id_rt == ex_rd)) & ~flush.
  - Stall lasts exactly one cycle: the bubble clears ex_mem_read, and the next cycle forwards from MEM/WB or EX/MEM.
- Flush plus hazard in the same cycle: stall_id = 0, bubble inserted.
- Outputs while ex_valid = 0: ex_reg_write/mem_read/mem_write = 0. Operands are don't-care, but must never be X after reset.
- Reset during a stall: the stage clears and stall_id deasserts in the following cycle.

Decomposition:
- Shared package mips_pkg:
  - ALU opcode constants: ADD 000, SUB 001, AND 010, OR 011, NOR 100, SLL 101, SRL 110, SLT 111.
  - DATA_W/REG_AW constants.
  - Stage-record struct of captured fields.
- One natural sub-module, forward_mux: single-source forwarding-priority logic, instantiated twice (rs, rt).

Test Plan:
- Reset with all inputs 1 -> ex_valid = 0, all ex control 0, stall_id = 0 next cycle.
- Normal capture: add r3, r1 (=5), r2 (=7), no hazards -> one cycle later ex_alu_a = 5, ex_alu_b = 7, ex_alu_sel = 000, ex_reg_write = 1.
- Double forward: EX rs = 4, exm_rd = 4 (result 0x11), mwb_rd = 4 (result 0x22) -> ex_alu_a = 0x11. Same with rs = 0 -> registered value used.
- Immediates and shifts:
  - imm 0xFFFF, sext = 1 -> ex_alu_b = 0xFFFFFFFF; sext = 0 -> 0x0000FFFF.
  - use_shamt, shamt 3, rt = 0x8 -> a = 0x8, b = 3.
- Load-use: lw r5 in EX, ID reads r5 -> stall_id = 1 for exactly one cycle, bubble then instruction. Operand taken from exm_result after 1 cycle.
- Flush during hazard -> stall_id = 0, bubble loaded, ID instruction never reaches ex_valid.
